// File: rtl/a51_pkg.sv
// rtl/a51_pkg.sv - shared state enum, phase lengths, register geometry and majority helper for A5/1
package a51_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_KEY,
    ST_FRAME,
    ST_MIX,
    ST_OUT
  } a51_state_t;

  localparam int A51_KEY_BITS   = 64;
  localparam int A51_FRAME_BITS = 22;
  localparam int A51_MIX_CYCLES = 101;
  localparam int A51_KS_BITS    = 228;
  localparam int A51_CNT_W      = 8;

  localparam int A51_R1_LEN = 19;
  localparam int A51_R2_LEN = 22;
  localparam int A51_R3_LEN = 23;
  localparam int A51_R1_CB  = 8;
  localparam int A51_R2_CB  = 10;
  localparam int A51_R3_CB  = 10;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/a51_sequencer.sv
// rtl/a51_sequencer.sv - phase sequencer owning clear, load, majority clocking and keystream handshake
module a51_sequencer
  import a51_pkg::*;
#(
  parameter int KEY_BITS   = A51_KEY_BITS,
  parameter int FRAME_BITS = A51_FRAME_BITS,
  parameter int MIX_CYCLES = A51_MIX_CYCLES,
  parameter int KS_BITS    = A51_KS_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [KEY_BITS-1:0]   key,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [2:0]            lfsr_q,
  input  logic [2:0]            lfsr_cb,
  output logic [2:0]            lfsr_clk_en,
  output logic                  lfsr_d,
  output logic                  lfsr_clr_n,
  output logic                  busy,
  output logic                  ks_bit,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic                  done
);

  localparam int KW = $clog2(KEY_BITS);
  localparam int FW = $clog2(FRAME_BITS);

  a51_state_t           state, state_nxt;
  logic [A51_CNT_W-1:0] cnt, cnt_nxt;
  logic [KEY_BITS-1:0]  key_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic                 lfsr_d_nxt, done_nxt;
  logic                 maj, xfer, last;
  logic [2:0]           maj_en;
  logic [KW-1:0]        key_idx;
  logic [FW-1:0]        frame_idx;

  assign maj    = maj3(lfsr_cb);
  assign maj_en = {lfsr_cb[2] == maj, lfsr_cb[1] == maj, lfsr_cb[0] == maj};
  assign xfer   = (state == ST_OUT) & ks_valid & ks_ready;
  assign last   = (cnt == '0);
  assign ks_bit = ^lfsr_q;

  // Bit presented in the following cycle of a load phase; the counter runs down, bits go LSB first.
  assign key_idx   = KW'(KEY_BITS - int'(cnt));
  assign frame_idx = FW'(FRAME_BITS - int'(cnt));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      ks_valid   <= 1'b0;
      done       <= 1'b0;
      lfsr_d     <= 1'b0;
      lfsr_clr_n <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      busy       <= (state_nxt != ST_IDLE);
      ks_valid   <= (state_nxt == ST_OUT);
      done       <= done_nxt;
      lfsr_d     <= lfsr_d_nxt;
      lfsr_clr_n <= (state_nxt != ST_CLEAR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q   <= '0;
      frame_q <= '0;
    end else if (state == ST_IDLE && start && !abort) begin
      key_q   <= key;
      frame_q <= frame;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_CLEAR;
        ST_CLEAR: begin
          state_nxt = ST_KEY;
          cnt_nxt   = A51_CNT_W'(KEY_BITS - 1);
        end
        ST_KEY: begin
          if (last) begin
            state_nxt = ST_FRAME;
            cnt_nxt   = A51_CNT_W'(FRAME_BITS - 1);
          end else cnt_nxt = cnt - 1'b1;
        end
        ST_FRAME: begin
          if (last) begin
            state_nxt = ST_MIX;
            cnt_nxt   = A51_CNT_W'(MIX_CYCLES - 1);
          end else cnt_nxt = cnt - 1'b1;
        end
        ST_MIX: begin
          if (last) begin
            state_nxt = ST_OUT;
            cnt_nxt   = A51_CNT_W'(KS_BITS - 1);
          end else cnt_nxt = cnt - 1'b1;
        end
        ST_OUT: begin
          if (xfer) begin
            if (last) state_nxt = ST_IDLE;
            else cnt_nxt = cnt - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lfsr_clk_en = 3'b000;
    lfsr_d_nxt  = 1'b0;
    done_nxt    = (state == ST_OUT) & xfer & last & !abort;
    case (state)
      ST_KEY, ST_FRAME: lfsr_clk_en = 3'b111;
      ST_MIX:           lfsr_clk_en = maj_en;
      ST_OUT:           if (xfer) lfsr_clk_en = maj_en;
      default:          lfsr_clk_en = 3'b000;
    endcase
    if (state_nxt == ST_KEY)
      lfsr_d_nxt = (state == ST_CLEAR) ? key_q[0] : key_q[key_idx];
    else if (state_nxt == ST_FRAME)
      lfsr_d_nxt = (state == ST_KEY) ? frame_q[0] : frame_q[frame_idx];
  end

endmodule

// File: tb/tb_a51_sequencer.sv
// tb/tb_a51_sequencer.sv - scoreboard bench: behavioural A5/1 registers around the sequencer
module tb_a51_sequencer;
  import a51_pkg::*;

  localparam logic [63:0]  GK   = 64'hEFCDAB8967452312;
  localparam logic [21:0]  GF   = 22'h134;
  localparam logic [119:0] GOLD = 120'h534EAA582FE8151AB6E1855A728C00;
  localparam int P2 = A51_R1_LEN;
  localparam int P3 = A51_R1_LEN + A51_R2_LEN;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, ks_ready;
  logic [63:0] key;
  logic [21:0] frame;
  logic [2:0]  lfsr_q, lfsr_cb, lfsr_clk_en;
  logic        lfsr_d, lfsr_clr_n, busy, ks_bit, ks_valid, done;
  logic [63:0] lfsr_s;
  logic        force_cb;
  logic [2:0]  cb_ovr;
  wire         lclr_n = reset_n & lfsr_clr_n;

  int checks = 0, errors = 0;
  logic exp_q[$];
  int xfer_cnt, done_cnt, done_cyc, first_valid, clr_cnt, clr_cyc, en7_cnt, mix_cnt;
  logic [227:0] got_v;

  always #5 clk = ~clk;

  a51_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key(key), .frame(frame),
    .lfsr_q(lfsr_q), .lfsr_cb(lfsr_cb), .lfsr_clk_en(lfsr_clk_en), .lfsr_d(lfsr_d),
    .lfsr_clr_n(lfsr_clr_n), .busy(busy), .ks_bit(ks_bit), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .done(done)
  );

  // State packs R1 in [18:0], R2 in [40:19], R3 in [63:41]; feedback taps are the A5/1 polynomials.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [2:0] en, input logic b);
    logic [A51_R1_LEN-1:0] a;
    logic [A51_R2_LEN-1:0] c2;
    logic [A51_R3_LEN-1:0] c3;
    a = s[P2-1:0]; c2 = s[P3-1:P2]; c3 = s[63:P3];
    if (en[0]) a  = {a[17:0],  (^(a  & 19'h72000))  ^ b};
    if (en[1]) c2 = {c2[20:0], (^(c2 & 22'h300000)) ^ b};
    if (en[2]) c3 = {c3[21:0], (^(c3 & 23'h700080)) ^ b};
    return {c3, c2, a};
  endfunction

  function automatic logic [2:0] cb_of(input logic [63:0] s);
    return {s[P3 + A51_R3_CB], s[P2 + A51_R2_CB], s[A51_R1_CB]};
  endfunction

  function automatic logic [2:0] exp_en(input logic [2:0] cb);
    logic m;
    m = (cb[0] & cb[1]) | (cb[1] & cb[2]) | (cb[0] & cb[2]);
    return {cb[2] == m, cb[1] == m, cb[0] == m};
  endfunction

  function automatic logic [227:0] a51_ref(input logic [63:0] k, input logic [21:0] f);
    logic [63:0]  s;
    logic [85:0]  lv;
    logic [227:0] o;
    s = '0; o = '0; lv = {f, k};
    for (int i = 0; i < 86; i++) begin
      s  = lfsr_step(s, 3'b111, lv[0]);
      lv = lv >> 1;
    end
    for (int i = 0; i < 100; i++) s = lfsr_step(s, exp_en(cb_of(s)), 1'b0);
    for (int i = 0; i < 228; i++) begin
      s = lfsr_step(s, exp_en(cb_of(s)), 1'b0);
      o = {s[63] ^ s[P3-1] ^ s[P2-1], o[227:1]};
    end
    return o;
  endfunction

  function automatic logic [119:0] pack114(input logic [227:0] v);
    logic [119:0] p;
    p = '0;
    for (int i = 0; i < 114; i++) begin
      p = {p[118:0], v[0]};
      v = v >> 1;
    end
    return p << 6;
  endfunction

  always @(posedge clk or negedge lclr_n)
    if (!lclr_n) lfsr_s <= '0;
    else         lfsr_s <= lfsr_step(lfsr_s, lfsr_clk_en, lfsr_d);

  assign lfsr_q  = {lfsr_s[63], lfsr_s[P3-1], lfsr_s[P2-1]};
  assign lfsr_cb = force_cb ? cb_ovr : cb_of(lfsr_s);

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_clk_en"},   lfsr_clk_en, 3'b000);
    check_val({tag, "_lfsr_d"},   lfsr_d,      1'b0);
    check_val({tag, "_clr_n"},    lfsr_clr_n,  1'b1);
    check_val({tag, "_busy"},     busy,        1'b0);
    check_val({tag, "_ks_valid"}, ks_valid,    1'b0);
    check_val({tag, "_done"},     done,        1'b0);
  endtask

  // Entered and left just after a rising edge; cycle 0 is the cycle in which start is presented.
  task automatic run_session(input bit rnd, input bit pulses, input int abort_at, input int reset_at,
                             input bit frc, input bit sb, input logic [63:0] k, input logic [21:0] f);
    int rel;
    logic [227:0] r;
    key = k; frame = f; force_cb = frc; start = 1'b1; ks_ready = 1'b1; cb_ovr = 3'b000;
    xfer_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid = -1;
    clr_cnt = 0; clr_cyc = -1; en7_cnt = 0; mix_cnt = 0; got_v = '0;
    if (sb) begin
      r = a51_ref(k, f);
      for (int i = 0; i < 228; i++) begin
        exp_q.push_back(r[0]);
        r = r >> 1;
      end
    end
    rel = 0;
    while (1) begin
      @(negedge clk);
      if (!lfsr_clr_n) begin clr_cnt++; clr_cyc = rel; end
      if (rel >= 1 && rel <= 87 && lfsr_clk_en == 3'b111) en7_cnt++;
      if (rel >= 88 && rel <= 188) begin
        mix_cnt++;
        check_val("mix_en", lfsr_clk_en, exp_en(lfsr_cb));
        check_val("mix_en_min2", 1'($countones(lfsr_clk_en) >= 2), 1'b1);
      end
      if (ks_valid) begin
        if (first_valid < 0) first_valid = rel;
        if (ks_ready) begin
          if (sb) begin
            if (exp_q.size() == 0) check_val("sb_underflow", exp_q.size(), 1);
            else check_val("ks_bit", ks_bit, exp_q.pop_front());
          end
          got_v = {ks_bit, got_v[227:1]};
          xfer_cnt++;
        end else begin
          check_val("stall_en", lfsr_clk_en, 3'b000);
        end
      end
      if (done) begin done_cnt++; done_cyc = rel; end
      if (done_cnt > 0) break;
      if (rel >= 3000) begin
        check_val("session_timeout", rel, 0);
        break;
      end
      @(posedge clk); #1;
      rel++;
      start = pulses && (rel == 5 || rel == 200);
      if (rel == 3) begin key = {$urandom, $urandom}; frame = 22'($urandom); end
      ks_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      cb_ovr = rel[2:0];
      if (abort_at >= 0 && ks_valid && xfer_cnt == abort_at) begin abort = 1'b1; break; end
      if (reset_at >= 0 && ks_valid && xfer_cnt == reset_at) begin reset_n = 1'b0; break; end
    end
    if (done_cnt > 0 || rel >= 3000) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b0;
    key = '0; frame = '0; force_cb = 1'b0; cb_ovr = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("ref_golden", pack114(a51_ref(GK, GF)), GOLD);

    // Golden vector, ready held high, stray start pulses and key port changes after capture.
    run_session(1'b0, 1'b1, -1, -1, 1'b0, 1'b1, GK, GF);
    check_val("a_first_valid", first_valid, 189);
    check_val("a_done_cyc",    done_cyc,    417);
    check_val("a_done_cnt",    done_cnt,    1);
    check_val("a_clr_cnt",     clr_cnt,     1);
    check_val("a_clr_cyc",     clr_cyc,     1);
    check_val("a_en111_cnt",   en7_cnt,     86);
    check_val("a_xfers",       xfer_cnt,    228);
    check_val("a_golden",      pack114(got_v), GOLD);
    check_val("a_sb_left",     exp_q.size(), 0);
    check_val("a_done_width",  done,        1'b0);
    check_val("a_busy_after",  busy,        1'b0);

    // Backpressure at roughly 30% ready.
    run_session(1'b1, 1'b0, -1, -1, 1'b0, 1'b1, GK, GF);
    check_val("b_first_valid", first_valid, 189);
    check_val("b_xfers",       xfer_cnt,    228);
    check_val("b_done_cnt",    done_cnt,    1);
    check_val("b_golden",      pack114(got_v), GOLD);
    check_val("b_sb_left",     exp_q.size(), 0);

    // Asynchronous reset in the middle of the keystream.
    run_session(1'b0, 1'b0, -1, 50, 1'b0, 1'b1, {$urandom, $urandom}, 22'($urandom));
    #1;
    check_reset("mid");
    check_val("c_xfers", xfer_cnt, 50);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_session(1'b0, 1'b0, -1, -1, 1'b0, 1'b1, GK, GF);
    check_val("d_done_cyc", done_cyc, 417);
    check_val("d_golden",   pack114(got_v), GOLD);
    check_val("d_sb_left",  exp_q.size(), 0);

    // Abort coinciding with the transfer of bit 10.
    run_session(1'b0, 1'b0, 10, -1, 1'b0, 1'b1, GK, GF);
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("e_busy_idle",  busy,     1'b0);
    check_val("e_valid_idle", ks_valid, 1'b0);
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("e_no_done", done_cnt, 0);
    check_val("e_xfers",   xfer_cnt, 10);
    exp_q.delete();
    @(posedge clk); #1;
    run_session(1'b0, 1'b0, -1, -1, 1'b0, 1'b1, GK, GF);
    check_val("f_done_cyc", done_cyc, 417);
    check_val("f_golden",   pack114(got_v), GOLD);

    // Forced clocking-tap sweep across the whole mixing phase.
    run_session(1'b0, 1'b0, 0, -1, 1'b1, 1'b0, {$urandom, $urandom}, 22'($urandom));
    @(posedge clk); #1;
    abort = 1'b0; force_cb = 1'b0;
    check_val("g_mix_cycles", mix_cnt, 101);
    check_val("g_busy_idle",  busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
